// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared constants for the memory-mapped I/O port bank
package io_pkg;

    localparam logic [1:0] ADDR_MODE_RD  = 2'b00;
    localparam logic [1:0] ADDR_MODE_PC  = 2'b01;
    localparam logic [1:0] ADDR_MODE_WRT = 2'b10;

    // Per-port register offsets within each 4-byte port slot
    localparam logic [1:0] OFF_DATA     = 2'd0;
    localparam logic [1:0] OFF_DIR      = 2'd1;
    localparam logic [1:0] OFF_IRQ_EN   = 2'd2;
    localparam logic [1:0] OFF_IRQ_STAT = 2'd3;

    // Beeper register offsets relative to the slot after the last port
    localparam logic [1:0] OFF_DIV_LO = 2'd0;
    localparam logic [1:0] OFF_DIV_HI = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;

    localparam int IRQ_EDGE_RISE = 0;
    localparam int IRQ_EDGE_FALL = 1;
    localparam int IRQ_EDGE_BOTH = 2;

endpackage

// File: rtl/beep_gen.sv
// rtl/beep_gen.sv - programmable square-wave beeper with divider and clear-on-write
module beep_gen
    import io_pkg::*;
(
    input  logic        clk,
    input  logic        rstIn,
    input  logic        wr_en,
    input  logic [1:0]  wr_sel,
    input  logic [7:0]  wdata,
    output logic [15:0] div,
    output logic        en,
    output logic        beeper
);

    logic [15:0] div_n;
    logic [15:0] cnt;
    logic        en_n;
    logic        reg_wr;

    assign reg_wr = wr_en && (wr_sel inside {OFF_DIV_LO, OFF_DIV_HI, OFF_CTRL});

    always_comb begin
        div_n = div;
        en_n  = en;
        if (wr_en) begin
            case (wr_sel)
                OFF_DIV_LO: div_n[7:0]  = wdata;
                OFF_DIV_HI: div_n[15:8] = wdata;
                OFF_CTRL:   en_n        = wdata[0];
                default:    ;
            endcase
        end
    end

    // Decisions use the post-write settings so disabling silences the tone on the same edge
    always_ff @(posedge clk or negedge rstIn) begin
        if (!rstIn) begin
            div    <= '0;
            en     <= 1'b0;
            cnt    <= '0;
            beeper <= 1'b0;
        end else begin
            div <= div_n;
            en  <= en_n;
            if (!en_n || div_n == 16'd0) begin
                cnt    <= '0;
                beeper <= 1'b0;
            end else if (reg_wr) begin
                cnt <= '0;
            end else if (cnt == div) begin
                cnt    <= '0;
                beeper <= ~beeper;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/mmio_port_bank.sv
// rtl/mmio_port_bank.sv - GPIO port bank with edge interrupts and beeper on the Z8 bus
module mmio_port_bank
    import io_pkg::*;
#(
    parameter logic [23:0] BASE_ADDR = 24'h00FFF0,
    parameter int          NUM_PORTS = 2,
    parameter int          WIDTH     = 8,
    parameter int          IRQ_EDGE  = 0
) (
    input  logic                         clk,
    input  logic                         rstIn,
    input  logic [1:0]                   memReadWrite,
    input  logic [23:0]                  addressLinesIn,
    input  logic [7:0]                   dataBusIn,
    output logic [7:0]                   readData,
    output logic                         regHit,
    input  logic [NUM_PORTS*WIDTH-1:0]   pinIn,
    output logic [NUM_PORTS*WIDTH-1:0]   pinOut,
    output logic [NUM_PORTS*WIDTH-1:0]   pinOe,
    output logic [NUM_PORTS-1:0]         irqVec,
    output logic                         beeper
);

    localparam int WIN = 4 * NUM_PORTS + 4;

    logic [23:0] off;
    logic [1:0]  idx;
    logic [1:0]  sel;
    logic        wr_en;
    logic [1:0]  arm;
    logic        armed;
    logic [NUM_PORTS-1:0][7:0] port_rd;
    logic [7:0]  beep_rd;
    logic [15:0] div;
    logic        beep_en;
    logic [WIDTH-1:0] wdata;

    // Addresses below the base wrap to large offsets and so miss the window
    assign off    = addressLinesIn - BASE_ADDR;
    assign idx    = off[3:2];
    assign sel    = off[1:0];
    assign regHit = (memReadWrite == ADDR_MODE_RD || memReadWrite == ADDR_MODE_WRT)
                    && (off < 24'(WIN));
    assign wr_en  = regHit && (memReadWrite == ADDR_MODE_WRT);
    assign wdata  = dataBusIn[WIDTH-1:0];
    assign armed  = (arm == 2'd3);

    // Hold off edge detection while the synchroniser fills after reset
    always_ff @(posedge clk or negedge rstIn) begin
        if (!rstIn) begin
            arm <= '0;
        end else if (!armed) begin
            arm <= arm + 2'd1;
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [WIDTH-1:0] sync1, sync2, hist;
        logic [WIDTH-1:0] dout, dir, ien, stat;
        logic [WIDTH-1:0] rise, fall, det, clr;
        logic             port_wr;

        assign port_wr = wr_en && (idx == 2'(p));
        assign rise    = sync2 & ~hist;
        assign fall    = ~sync2 & hist;
        assign det     = ((IRQ_EDGE == IRQ_EDGE_BOTH) ? (rise | fall) :
                          (IRQ_EDGE == IRQ_EDGE_FALL) ? fall : rise)
                         & ~dir & {WIDTH{armed}};
        assign clr     = (port_wr && sel == OFF_IRQ_STAT) ? wdata : '0;

        // History follows sync2 every cycle, so a bit turned back into an input sees no stale edge
        always_ff @(posedge clk or negedge rstIn) begin
            if (!rstIn) begin
                sync1 <= '0;
                sync2 <= '0;
                hist  <= '0;
                dout  <= '0;
                dir   <= '0;
                ien   <= '0;
                stat  <= '0;
            end else begin
                sync1 <= pinIn[p*WIDTH +: WIDTH];
                sync2 <= sync1;
                hist  <= sync2;
                if (port_wr && sel == OFF_DATA)   dout <= wdata;
                if (port_wr && sel == OFF_DIR)    dir  <= wdata;
                if (port_wr && sel == OFF_IRQ_EN) ien  <= wdata;
                stat <= (stat & ~clr) | det;
            end
        end

        assign port_rd[p] = (sel == OFF_DATA)   ? 8'(sync2) :
                            (sel == OFF_DIR)    ? 8'(dir)   :
                            (sel == OFF_IRQ_EN) ? 8'(ien)   : 8'(stat);
        assign irqVec[p]                  = |(stat & ien);
        assign pinOut[p*WIDTH +: WIDTH]   = dout;
        assign pinOe[p*WIDTH +: WIDTH]    = dir;
    end

    beep_gen u_beep (
        .clk    (clk),
        .rstIn  (rstIn),
        .wr_en  (wr_en && idx == 2'(NUM_PORTS)),
        .wr_sel (sel),
        .wdata  (dataBusIn),
        .div    (div),
        .en     (beep_en),
        .beeper (beeper)
    );

    always_comb begin
        case (sel)
            OFF_DIV_LO: beep_rd = div[7:0];
            OFF_DIV_HI: beep_rd = div[15:8];
            OFF_CTRL:   beep_rd = {7'd0, beep_en};
            default:    beep_rd = 8'd0;
        endcase
    end

    always_comb begin
        readData = 8'd0;
        if (regHit) begin
            if (idx == 2'(NUM_PORTS)) begin
                readData = beep_rd;
            end else begin
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (idx == 2'(p)) readData = port_rd[p];
                end
            end
        end
    end

endmodule

// File: tb/tb_mmio_port_bank.sv
// tb/tb_mmio_port_bank.sv - randomized self-checking bench for mmio_port_bank
module tb_mmio_port_bank;
    import io_pkg::*;

    localparam int          NP   = 2;
    localparam int          W    = 8;
    localparam int          NB   = NP * W;
    localparam logic [23:0] BASE = 24'h00FFF0;
    localparam int          WIN  = 4 * NP + 4;

    logic          clk;
    logic          rstIn;
    logic [1:0]    mode;
    logic [23:0]   addr;
    logic [7:0]    dbus;
    logic [7:0]    readData;
    logic          regHit;
    logic [NB-1:0] pinIn;
    logic [NB-1:0] pinOut;
    logic [NB-1:0] pinOe;
    logic [NP-1:0] irqVec;
    logic          beeper;

    int n_total = 0;
    int n_pass  = 0;
    bit cmp_on  = 0;

    mmio_port_bank #(
        .BASE_ADDR (BASE),
        .NUM_PORTS (NP),
        .WIDTH     (W),
        .IRQ_EDGE  (0)
    ) dut (
        .clk            (clk),
        .rstIn          (rstIn),
        .memReadWrite   (mode),
        .addressLinesIn (addr),
        .dataBusIn      (dbus),
        .readData       (readData),
        .regHit         (regHit),
        .pinIn          (pinIn),
        .pinOut         (pinOut),
        .pinOe          (pinOe),
        .irqVec         (irqVec),
        .beeper         (beeper)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: registers as plain arrays, pins as the samples of the last three edges
    logic [W-1:0]  m_dout [NP];
    logic [W-1:0]  m_dir  [NP];
    logic [W-1:0]  m_en   [NP];
    logic [W-1:0]  m_stat [NP];
    logic [NB-1:0] smp0, smp1, smp2;
    int            age;
    logic [15:0]   m_div;
    logic          m_ben;
    int            t;
    logic          tone0;

    logic [23:0] b_off;
    logic        b_hit;
    logic        b_wr;
    int          b_q;
    int          b_r;
    assign b_off = addr - BASE;
    assign b_hit = (mode == ADDR_MODE_RD || mode == ADDR_MODE_WRT) && (int'(b_off) < WIN);
    assign b_wr  = b_hit && mode == ADDR_MODE_WRT;
    assign b_q   = int'(b_off) / 4;
    assign b_r   = int'(b_off) % 4;

    function automatic logic [W-1:0] det_of(int p);
        logic [W-1:0] nw, od;
        nw = smp1[p*W +: W];
        od = smp2[p*W +: W];
        if (age < 3) return '0;
        return nw & ~od & ~m_dir[p];
    endfunction

    function automatic logic tone_now();
        if (!m_ben || m_div == 16'd0) return 1'b0;
        return tone0 ^ (((t / (int'(m_div) + 1)) % 2) == 1);
    endfunction

    function automatic logic [15:0] next_div();
        logic [15:0] nd;
        nd = m_div;
        if (b_wr && b_q == NP && b_r == 0) nd[7:0]  = dbus;
        if (b_wr && b_q == NP && b_r == 1) nd[15:8] = dbus;
        return nd;
    endfunction

    function automatic logic next_en();
        if (b_wr && b_q == NP && b_r == 2) return dbus[0];
        return m_ben;
    endfunction

    function automatic logic [7:0] exp_rd();
        if (!b_hit) return 8'h00;
        if (b_q < NP) begin
            case (b_r)
                0:       return smp1[b_q*W +: W];
                1:       return m_dir[b_q];
                2:       return m_en[b_q];
                default: return m_stat[b_q];
            endcase
        end
        if (b_r == 0) return m_div[7:0];
        if (b_r == 1) return m_div[15:8];
        if (b_r == 2) return {7'd0, m_ben};
        return 8'h00;
    endfunction

    function automatic logic [NB-1:0] pack_out();
        logic [NB-1:0] v;
        for (int p = 0; p < NP; p++) v[p*W +: W] = m_dout[p];
        return v;
    endfunction

    function automatic logic [NB-1:0] pack_oe();
        logic [NB-1:0] v;
        for (int p = 0; p < NP; p++) v[p*W +: W] = m_dir[p];
        return v;
    endfunction

    function automatic logic [NP-1:0] exp_irq();
        logic [NP-1:0] v;
        for (int p = 0; p < NP; p++) v[p] = |(m_stat[p] & m_en[p]);
        return v;
    endfunction

    always @(posedge clk or negedge rstIn) begin
        if (!rstIn) begin
            smp0  <= '0;
            smp1  <= '0;
            smp2  <= '0;
            age   <= 0;
            m_div <= '0;
            m_ben <= 1'b0;
            t     <= 0;
            tone0 <= 1'b0;
            for (int p = 0; p < NP; p++) begin
                m_dout[p] <= '0;
                m_dir[p]  <= '0;
                m_en[p]   <= '0;
                m_stat[p] <= '0;
            end
        end else begin
            smp0 <= pinIn;
            smp1 <= smp0;
            smp2 <= smp1;
            if (age < 3) age <= age + 1;
            for (int p = 0; p < NP; p++) begin
                if (b_wr && b_q == p && b_r == 0) m_dout[p] <= dbus;
                if (b_wr && b_q == p && b_r == 1) m_dir[p]  <= dbus;
                if (b_wr && b_q == p && b_r == 2) m_en[p]   <= dbus;
                m_stat[p] <= (m_stat[p] & ~((b_wr && b_q == p && b_r == 3) ? dbus : 8'h00))
                             | det_of(p);
            end
            m_div <= next_div();
            m_ben <= next_en();
            if (!next_en() || next_div() == 16'd0) begin
                t     <= 0;
                tone0 <= 1'b0;
            end else if (b_wr && b_q == NP && b_r < 3) begin
                t     <= 0;
                tone0 <= tone_now();
            end else begin
                t <= t + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("cmp_readData", 32'(readData), 32'(exp_rd()));
            chk("cmp_regHit",   32'(regHit),   32'(b_hit));
            chk("cmp_pinOut",   32'(pinOut),   32'(pack_out()));
            chk("cmp_pinOe",    32'(pinOe),    32'(pack_oe()));
            chk("cmp_irqVec",   32'(irqVec),   32'(exp_irq()));
            chk("cmp_beeper",   32'(beeper),   32'(tone_now()));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [23:0] a, input logic [7:0] d);
        mode = ADDR_MODE_WRT;
        addr = a;
        dbus = d;
        @(posedge clk);
        #1;
        mode = 2'b11;
    endtask

    task automatic rd(input logic [23:0] a);
        mode = ADDR_MODE_RD;
        addr = a;
        #1;
    endtask

    initial begin
        rstIn = 1'b1;
        mode  = 2'b11;
        addr  = '0;
        dbus  = '0;
        pinIn = '1;
        #2 rstIn = 1'b0;
        #1 cmp_on = 1;
        repeat (10) @(posedge clk);
        #1 rstIn = 1'b1;
        chk("rst_pinOe",  32'(pinOe),  32'h0);
        chk("rst_pinOut", 32'(pinOut), 32'h0);
        chk("rst_irqVec", 32'(irqVec), 32'h0);
        chk("rst_beeper", 32'(beeper), 32'h0);
        tick(3);
        rd(24'h00FFF0);
        chk("rst_data_ff", 32'(readData), 32'hFF);
        tick(20);
        rd(24'h00FFF3);
        chk("rst_stat_quiet", 32'(readData), 32'h00);
        chk("rst_irq_quiet",  32'(irqVec),   32'h0);

        wr(24'h00FFF1, 8'hF0);
        wr(24'h00FFF0, 8'hA5);
        chk("dir_pinOe",  32'(pinOe[7:0]),  32'hF0);
        chk("data_pinOut", 32'(pinOut[7:0]), 32'hA5);
        rd(24'h00FFF1);
        chk("rd_dir",     32'(readData), 32'hF0);
        chk("rd_dir_hit", 32'(regHit),   32'h1);
        mode = ADDR_MODE_PC;
        addr = 24'h00FFF0;
        #1;
        chk("pc_nohit",  32'(regHit),   32'h0);
        chk("pc_rd0",    32'(readData), 32'h00);
        mode = 2'b11;

        pinIn = '0;
        tick(5);
        wr(24'h00FFF3, 8'hFF);
        wr(24'h00FFF2, 8'h01);
        rd(24'h00FFF3);
        pinIn[0] = 1'b1;
        tick(2);
        chk("edge_k1_stat", 32'(readData), 32'h00);
        tick(1);
        chk("edge_k2_stat", 32'(readData), 32'h01);
        chk("edge_k2_irq",  32'(irqVec[0]), 32'h1);
        wr(24'h00FFF3, 8'h01);
        chk("w1c_irq", 32'(irqVec[0]), 32'h0);
        pinIn[0] = 1'b0;
        tick(5);
        pinIn[0] = 1'b1;
        tick(2);
        wr(24'h00FFF3, 8'h01);
        rd(24'h00FFF3);
        chk("set_wins_stat", 32'(readData), 32'h01);
        chk("set_wins_irq",  32'(irqVec[0]), 32'h1);

        wr(24'h00FFF5, 8'h08);
        wr(24'h00FFF6, 8'hFF);
        chk("p1_dir_oe", 32'(pinOe[15:8]), 32'h08);
        pinIn[11] = 1'b1;
        tick(5);
        rd(24'h00FFF7);
        chk("p1_out_noset", 32'(readData), 32'h00);
        wr(24'h00FFF5, 8'h00);
        tick(5);
        rd(24'h00FFF7);
        chk("p1_dir_flip_noset", 32'(readData), 32'h00);
        chk("p1_irq_quiet",      32'(irqVec[1]), 32'h0);

        wr(24'h00FFF8, 8'h03);
        wr(24'h00FFF9, 8'h00);
        wr(24'h00FFFA, 8'h01);
        tick(3);
        chk("beep_e3", 32'(beeper), 32'h0);
        tick(1);
        chk("beep_e4", 32'(beeper), 32'h1);
        tick(4);
        chk("beep_e8", 32'(beeper), 32'h0);
        tick(2);
        wr(24'h00FFF9, 8'h00);
        tick(3);
        chk("beep_restart_hold", 32'(beeper), 32'h0);
        tick(1);
        chk("beep_restart_tog", 32'(beeper), 32'h1);
        wr(24'h00FFFA, 8'h00);
        chk("beep_disable", 32'(beeper), 32'h0);
        wr(24'h00FFFA, 8'h01);
        tick(4);
        chk("beep_on_again", 32'(beeper), 32'h1);
        #1 rstIn = 1'b0;
        #1;
        chk("beep_async_rst", 32'(beeper), 32'h0);
        chk("rst2_pinOe",     32'(pinOe),  32'h0);
        pinIn = '0;
        tick(2);
        rstIn = 1'b1;

        wr(24'h00FFF1, 8'h3C);
        rd(24'h00FFFB);
        chk("unused_rd",  32'(readData), 32'h00);
        chk("unused_hit", 32'(regHit),   32'h1);
        wr(24'h00FFFB, 8'h5A);
        chk("unused_wr_oe",  32'(pinOe),  32'h003C);
        chk("unused_wr_out", 32'(pinOut), 32'h0000);
        rd(24'h00FFFA);
        chk("unused_wr_ctrl", 32'(readData), 32'h00);

        for (int i = 0; i < 4000; i++) begin
            int r;
            r = int'($urandom_range(0, 19));
            addr = (r < 16) ? (BASE - 24'd2 + 24'(r)) : 24'($urandom);
            r = int'($urandom_range(0, 7));
            mode = (r < 3) ? ADDR_MODE_RD : (r < 6) ? ADDR_MODE_WRT : 2'($urandom);
            dbus = 8'($urandom);
            if (addr == 24'h00FFF9) dbus = 8'h00;
            if (addr == 24'h00FFF8) dbus = dbus & 8'h0F;
            if ($urandom_range(0, 3) == 0) pinIn = pinIn ^ (NB'($urandom) & NB'($urandom));
            tick(1);
        end
        mode = 2'b11;
        tick(2);
        cmp_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
